// File: rtl/icache_controller_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encodings,
// address/data widths and helpers deriving index/tag widths from SETS.
package icache_controller_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FETCH  = 2'd1;
   localparam logic [1:0] ST_UPDATE = 2'd2;

   localparam int ADDR_W      = 32;
   localparam int WORD_W      = 32;
   localparam int BLOCK_W     = 128;
   localparam int BYTE_BITS   = 2;
   localparam int OFFSET_BITS = 2;

   // Number of index bits for a cache with 'sets' lines.
   function automatic int index_bits(input int sets);
      return $clog2(sets);
   endfunction

   // Tag takes all address bits above byte, word offset and index fields.
   function automatic int tag_bits(input int sets);
      return ADDR_W - BYTE_BITS - OFFSET_BITS - $clog2(sets);
   endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache: one asynchronous read
// port for the hit compare and one synchronous write port used on refill.
module icache_line_array
   import icache_controller_pkg::*;
#(
   parameter int SETS  = 8,
   parameter int IDX_W = 3,
   parameter int TAG_W = 25
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [IDX_W-1:0]     i_rd_index,
   output logic                 o_rd_valid,
   output logic [TAG_W-1:0]     o_rd_tag,
   output logic [BLOCK_W-1:0]   o_rd_block,
   input  logic                 i_we,
   input  logic [IDX_W-1:0]     i_wr_index,
   input  logic [TAG_W-1:0]     i_wr_tag,
   input  logic [BLOCK_W-1:0]   i_wr_block
);

   logic [SETS-1:0]    r_valid;
   logic [TAG_W-1:0]   r_tag   [SETS];
   logic [BLOCK_W-1:0] r_block [SETS];

   // Valid bits: cleared by reset, set when a refilled line is written.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= '0;
      end else if (i_we) begin
         r_valid[i_wr_index] <= 1'b1;
      end
   end

   // Tag and data storage; contents are meaningless until the valid bit is set.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_tag[i_wr_index]   <= i_wr_tag;
         r_block[i_wr_index] <= i_wr_block;
      end
   end

   assign o_rd_valid = r_valid[i_rd_index];
   assign o_rd_tag   = r_tag[i_rd_index];
   assign o_rd_block = r_block[i_rd_index];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped read-only instruction cache. Hits answer combinationally in
// IDLE; a miss latches the line address, fetches the 128-bit block from
// instruction memory (FETCH) and writes it into the line array (UPDATE).
module icache_controller
   import icache_controller_pkg::*;
#(
   parameter int SETS = 8
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic [31:0]   ADDRESS,
   output logic [31:0]   INSTRUCTION,
   output logic          BUSYWAIT,
   output logic          MEM_READ,
   output logic [27:0]   MEM_ADDRESS,
   input  logic [127:0]  MEM_READDATA,
   input  logic          MEM_BUSYWAIT
);

   localparam int IDX_W = index_bits(SETS);
   localparam int TAG_W = tag_bits(SETS);

   logic [1:0]         r_state;
   logic [1:0]         w_next_state;
   logic [TAG_W-1:0]   r_miss_tag;
   logic [IDX_W-1:0]   r_miss_index;
   logic [BLOCK_W-1:0] r_fill_block;

   logic [TAG_W-1:0]   w_addr_tag;
   logic [IDX_W-1:0]   w_addr_index;
   logic [1:0]         w_offset;
   logic               w_rd_valid;
   logic [TAG_W-1:0]   w_rd_tag;
   logic [BLOCK_W-1:0] w_rd_block;
   logic               w_hit;
   logic               w_latch_miss;
   logic               w_capture;
   logic               w_we;
   logic [WORD_W-1:0]  w_word;
   logic               w_unused;

   assign w_addr_tag   = ADDRESS[ADDR_W-1 -: TAG_W];
   assign w_addr_index = ADDRESS[BYTE_BITS+OFFSET_BITS +: IDX_W];
   assign w_offset     = ADDRESS[BYTE_BITS +: OFFSET_BITS];
   assign w_unused     = ^ADDRESS[BYTE_BITS-1:0];

   icache_line_array #(
      .SETS  (SETS),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_lines (
      .i_clk      (CLK),
      .i_rst_n    (RESET),
      .i_rd_index (w_addr_index),
      .o_rd_valid (w_rd_valid),
      .o_rd_tag   (w_rd_tag),
      .o_rd_block (w_rd_block),
      .i_we       (w_we),
      .i_wr_index (r_miss_index),
      .i_wr_tag   (r_miss_tag),
      .i_wr_block (r_fill_block)
   );

   assign w_hit = w_rd_valid && (w_rd_tag == w_addr_tag);

   // Next-state logic plus the one-cycle strobes that latch, capture and write.
   always_comb begin
      w_next_state = r_state;
      w_latch_miss = 1'b0;
      w_capture    = 1'b0;
      w_we         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_hit) begin
               w_next_state = ST_FETCH;
               w_latch_miss = 1'b1;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (!MEM_BUSYWAIT) begin
               w_next_state = ST_UPDATE;
               w_capture    = 1'b1;
            end else begin
               w_next_state = ST_FETCH;
            end
         end
         ST_UPDATE: begin
            w_we         = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // FSM state register; reset abandons any refill in progress.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Missing line address, held stable so ADDRESS redirects cannot disturb a refill.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_miss_tag   <= '0;
         r_miss_index <= '0;
      end else if (w_latch_miss) begin
         r_miss_tag   <= w_addr_tag;
         r_miss_index <= w_addr_index;
      end
   end

   // Block returned by memory, taken only in the cycle memory stops stalling.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_fill_block <= '0;
      end else if (w_capture) begin
         r_fill_block <= MEM_READDATA;
      end
   end

   // Word select within the addressed line.
   always_comb begin
      w_word = w_rd_block[31:0];
      case (w_offset)
         2'd0:    w_word = w_rd_block[31:0];
         2'd1:    w_word = w_rd_block[63:32];
         2'd2:    w_word = w_rd_block[95:64];
         default: w_word = w_rd_block[127:96];
      endcase
   end

   // Outputs are forced quiet while reset is held.
   assign INSTRUCTION = RESET ? w_word : 32'd0;
   assign BUSYWAIT    = RESET && ((r_state != ST_IDLE) || !w_hit);
   assign MEM_READ    = (r_state == ST_FETCH);
   assign MEM_ADDRESS = {r_miss_tag, r_miss_index};

endmodule

// File: tb/tb_icache_controller.sv
// Directed self-checking bench for icache_controller (SETS = 8).
module tb_icache_controller;

   logic         CLK;
   logic         RESET;
   logic [31:0]  ADDRESS;
   logic [31:0]  INSTRUCTION;
   logic         BUSYWAIT;
   logic         MEM_READ;
   logic [27:0]  MEM_ADDRESS;
   logic [127:0] MEM_READDATA;
   logic         MEM_BUSYWAIT;

   int checks;
   int errors;

   localparam logic [127:0] BLK0 = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
   localparam logic [127:0] BLK1 = {32'hB100_0003, 32'hB100_0002, 32'hB100_0001, 32'hB100_0000};
   localparam logic [127:0] BLK2 = {32'hC200_0003, 32'hC200_0002, 32'hC200_0001, 32'hC200_0000};
   localparam logic [127:0] BLK3 = {32'hD300_0003, 32'hD300_0002, 32'hD300_0001, 32'hD300_0000};
   localparam logic [127:0] BLK4 = {32'hA400_0003, 32'hA400_0002, 32'hA400_0001, 32'hA400_0000};
   localparam logic [127:0] BLK7 = {32'hE700_0003, 32'hE700_0002, 32'hE700_0001, 32'hE700_0000};
   localparam logic [127:0] JUNK = {4{32'hDEAD_BEEF}};

   icache_controller #(.SETS(8)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .ADDRESS      (ADDRESS),
      .INSTRUCTION  (INSTRUCTION),
      .BUSYWAIT     (BUSYWAIT),
      .MEM_READ     (MEM_READ),
      .MEM_ADDRESS  (MEM_ADDRESS),
      .MEM_READDATA (MEM_READDATA),
      .MEM_BUSYWAIT (MEM_BUSYWAIT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   // Full miss sequence: IDLE miss cycle, lat+1 FETCH cycles, UPDATE, then the
   // hit in IDLE. Optionally redirects ADDRESS during the first FETCH cycle.
   task automatic miss_refill(input logic [31:0] addr, input int lat, input logic [127:0] blk,
                              input logic [27:0] exp_ma, input logic [31:0] exp_word,
                              input bit redirect, input logic [31:0] new_addr);
      ADDRESS = addr;
      MEM_BUSYWAIT = 1'b1;
      #1;
      checks++; if (BUSYWAIT !== 1'b1) begin errors++; $display("FAIL miss_detect addr=%h: BUSYWAIT got %b exp 1", addr, BUSYWAIT); end
      checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL miss_idle_memread addr=%h: got %b exp 0", addr, MEM_READ); end
      for (int i = 0; i <= lat; i++) begin
         tick();
         if (redirect && i == 0) begin
            ADDRESS = new_addr;
            #1;
         end
         checks++; if (MEM_READ !== 1'b1) begin errors++; $display("FAIL fetch_memread addr=%h cyc=%0d: got %b exp 1", addr, i, MEM_READ); end
         checks++; if (MEM_ADDRESS !== exp_ma) begin errors++; $display("FAIL fetch_memaddr addr=%h cyc=%0d: got %h exp %h", addr, i, MEM_ADDRESS, exp_ma); end
         checks++; if (BUSYWAIT !== 1'b1) begin errors++; $display("FAIL fetch_busy addr=%h cyc=%0d: got %b exp 1", addr, i, BUSYWAIT); end
         if (i == lat) begin
            MEM_BUSYWAIT = 1'b0;
            MEM_READDATA = blk;
         end
      end
      tick();
      checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL update_memread addr=%h: got %b exp 0", addr, MEM_READ); end
      checks++; if (BUSYWAIT !== 1'b1) begin errors++; $display("FAIL update_busy addr=%h: got %b exp 1", addr, BUSYWAIT); end
      MEM_BUSYWAIT = 1'b1;
      MEM_READDATA = JUNK;
      tick();
      if (!redirect) begin
         checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL refill_hit_busy addr=%h: got %b exp 0", addr, BUSYWAIT); end
         checks++; if (INSTRUCTION !== exp_word) begin errors++; $display("FAIL refill_hit_instr addr=%h: got %h exp %h", addr, INSTRUCTION, exp_word); end
         checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL refill_hit_memread addr=%h: got %b exp 0", addr, MEM_READ); end
      end
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      ADDRESS = 32'h0000_0000;
      MEM_BUSYWAIT = 1'b1;
      MEM_READDATA = JUNK;
      tick();
      tick();
      checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", BUSYWAIT); end
      checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL reset_memread: got %b exp 0", MEM_READ); end
      checks++; if (MEM_ADDRESS !== 28'h0) begin errors++; $display("FAIL reset_memaddr: got %h exp 0", MEM_ADDRESS); end
      checks++; if (INSTRUCTION !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h exp 0", INSTRUCTION); end
      RESET = 1'b1;
      #1;
   endtask

   task automatic test_cold_miss();
      miss_refill(32'h0000_0000, 3, BLK0, 28'h000_0000, 32'h0000_0000, 1'b0, 32'h0);
   endtask

   task automatic test_spatial_hit();
      logic [31:0] addrs [3];
      logic [31:0] words [3];
      addrs = '{32'h4, 32'h8, 32'hC};
      words = '{32'h1, 32'h2, 32'h3};
      for (int i = 0; i < 3; i++) begin
         ADDRESS = addrs[i];
         #1;
         checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL spatial_busy addr=%h: got %b exp 0", addrs[i], BUSYWAIT); end
         checks++; if (INSTRUCTION !== words[i]) begin errors++; $display("FAIL spatial_instr addr=%h: got %h exp %h", addrs[i], INSTRUCTION, words[i]); end
         tick();
         checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL spatial_memread addr=%h: got %b exp 0", addrs[i], MEM_READ); end
      end
   endtask

   task automatic test_conflict();
      miss_refill(32'h0000_0080, 1, BLK1, 28'h000_0008, 32'hB100_0000, 1'b0, 32'h0);
      ADDRESS = 32'h0000_0004;
      #1;
      checks++; if (BUSYWAIT !== 1'b1) begin errors++; $display("FAIL conflict_evicted: BUSYWAIT got %b exp 1", BUSYWAIT); end
      miss_refill(32'h0000_0004, 0, BLK0, 28'h000_0000, 32'h0000_0001, 1'b0, 32'h0);
   endtask

   task automatic test_redirect();
      miss_refill(32'h0000_0040, 2, BLK4, 28'h000_0004, 32'h0, 1'b1, 32'h0000_0100);
      checks++; if (BUSYWAIT !== 1'b1) begin errors++; $display("FAIL redirect_new_miss: BUSYWAIT got %b exp 1", BUSYWAIT); end
      miss_refill(32'h0000_0100, 1, BLK2, 28'h000_0010, 32'hC200_0000, 1'b0, 32'h0);
      ADDRESS = 32'h0000_0044;
      #1;
      checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL redirect_line4_busy: got %b exp 0", BUSYWAIT); end
      checks++; if (INSTRUCTION !== 32'hA400_0001) begin errors++; $display("FAIL redirect_line4_instr: got %h exp a4000001", INSTRUCTION); end
   endtask

   task automatic test_reset_mid_miss();
      miss_refill(32'h0000_0008, 0, BLK0, 28'h000_0000, 32'h0000_0002, 1'b0, 32'h0);
      ADDRESS = 32'h0000_0010;
      MEM_BUSYWAIT = 1'b1;
      tick();
      checks++; if (MEM_READ !== 1'b1) begin errors++; $display("FAIL midrst_fetch: got %b exp 1", MEM_READ); end
      RESET = 1'b0;
      #1;
      checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL midrst_memread: got %b exp 0", MEM_READ); end
      checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b exp 0", BUSYWAIT); end
      checks++; if (MEM_ADDRESS !== 28'h0) begin errors++; $display("FAIL midrst_memaddr: got %h exp 0", MEM_ADDRESS); end
      MEM_BUSYWAIT = 1'b0;
      MEM_READDATA = JUNK;
      tick();
      tick();
      checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL midrst_late_resp: got %b exp 0", MEM_READ); end
      RESET = 1'b1;
      MEM_BUSYWAIT = 1'b1;
      ADDRESS = 32'h0000_0044;
      #1;
      checks++; if (BUSYWAIT !== 1'b1) begin errors++; $display("FAIL midrst_line4_cleared: BUSYWAIT got %b exp 1", BUSYWAIT); end
      miss_refill(32'h0000_0000, 0, BLK0, 28'h000_0000, 32'h0000_0000, 1'b0, 32'h0);
   endtask

   task automatic test_pc_max();
      miss_refill(32'hFFFF_FFFC, 0, BLK7, 28'hFFF_FFFF, 32'hE700_0003, 1'b0, 32'h0);
   endtask

   task automatic test_long_stall();
      miss_refill(32'h0000_0028, 50, BLK3, 28'h000_0002, 32'hD300_0002, 1'b0, 32'h0);
      ADDRESS = 32'h0000_0000;
      #1;
      checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL long_other_line_busy: got %b exp 0", BUSYWAIT); end
      checks++; if (INSTRUCTION !== 32'h0) begin errors++; $display("FAIL long_other_line_instr: got %h exp 0", INSTRUCTION); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_cold_miss();
      test_spatial_hit();
      test_conflict();
      test_redirect();
      test_reset_mid_miss();
      test_pc_max();
      test_long_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
